// File: rtl/excp_pkg.sv
// Shared types and helpers for the exception controller.
// Codes are 1-based source indices so that 0 can stand for "no exception".
package excp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } excpState_t;

  localparam int ExcepCode_NONE = 0;

  function automatic int unsigned idx2code(int unsigned idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/excp_prio_enc.sv
// Lowest-index-wins priority encoder; index 0 is the highest priority.
// Purely combinational. anyVld flags that at least one bit is set.
module excp_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               anyVld
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx    = '0;
    anyVld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx    = IDX_W'(i);
        anyVld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/excp_ctrl.sv
// Exception controller: per-source pending/overrun tracking, priority pick
// of the enabled events, and a req/ack then done service handshake.
//
// state   | meaning
// IDLE    | nothing in service; picks the next eligible source
// REQ     | req high, waiting for the core to ack the latched source
// SERVICE | trap taken, waiting for the handler return (done)
module excp_ctrl
  import excp_pkg::*;
#(
  parameter int                 NUM_SRC  = 8,
  parameter int                 CODE_W   = 4,
  parameter logic [NUM_SRC-1:0] NMI_MASK = NUM_SRC'(1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] srcVld,
  input  logic [NUM_SRC-1:0] srcMask,
  input  logic               ack,
  input  logic               done,
  input  logic               ovrClr,
  output logic               req,
  output logic [CODE_W-1:0]  excepCode,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun,
  output logic               busy
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  excpState_t         state;
  logic [IDX_W-1:0]   sel;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clrVec;
  logic [NUM_SRC-1:0] ovrSet;
  logic [IDX_W-1:0]   encIdx;
  logic               encAny;

  // A source firing in the same cycle its pending bit is acked is a fresh
  // event, not an overrun, and it re-arms pending.
  always_comb begin
    elig   = (pending | srcVld) & (srcMask | NMI_MASK);
    clrVec = '0;
    if (state == REQ && ack) clrVec[sel] = 1'b1;
    ovrSet = srcVld & pending & ~clrVec;
  end

  excp_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prioEnc (
    .vec    (elig),
    .idx    (encIdx),
    .anyVld (encAny)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~clrVec) | srcVld;
      overrun <= ovrClr ? ovrSet : (overrun | ovrSet);
    end
  end

  // Outputs are registered alongside the state so nothing depends
  // combinationally on the inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sel       <= '0;
      req       <= 1'b0;
      busy      <= 1'b0;
      excepCode <= CODE_W'(ExcepCode_NONE);
    end else begin
      case (state)
        IDLE: begin
          if (encAny) begin
            state     <= REQ;
            sel       <= encIdx;
            req       <= 1'b1;
            busy      <= 1'b1;
            excepCode <= CODE_W'(idx2code(32'(encIdx)));
          end
        end
        REQ: begin
          if (ack) begin
            state <= SERVICE;
            req   <= 1'b0;
          end
        end
        SERVICE: begin
          if (done) begin
            state     <= IDLE;
            busy      <= 1'b0;
            excepCode <= CODE_W'(ExcepCode_NONE);
          end
        end
        default: begin
          state     <= IDLE;
          req       <= 1'b0;
          busy      <= 1'b0;
          excepCode <= CODE_W'(ExcepCode_NONE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_excp_ctrl.sv
// Self-checking bench for excp_ctrl: directed scenarios plus a randomized
// run compared every cycle against a behavioural model.
module tb_excp_ctrl;

  localparam logic [7:0] NMI = 8'h01;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] srcVld = '0;
  logic [7:0] srcMask = '0;
  logic       ack = 1'b0;
  logic       done = 1'b0;
  logic       ovrClr = 1'b0;
  logic       req;
  logic [3:0] excepCode;
  logic [7:0] pending;
  logic [7:0] overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Model: mState 0 = idle, 1 = requesting, 2 = in service
  int       mState = 0;
  int       mSel = 0;
  bit [7:0] mPend = '0;
  bit [7:0] mOvr = '0;

  excp_ctrl #(.NUM_SRC(8), .CODE_W(4), .NMI_MASK(8'b0000_0001)) dut (
    .clk(clk), .rst(rst), .srcVld(srcVld), .srcMask(srcMask), .ack(ack),
    .done(done), .ovrClr(ovrClr), .req(req), .excepCode(excepCode),
    .pending(pending), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    mState = 0; mSel = 0; mPend = '0; mOvr = '0;
  endfunction

  function automatic void modelStep();
    int       clrIdx = -1;
    int       pick = -1;
    bit [7:0] setv = '0;
    if (mState == 1 && ack) clrIdx = mSel;
    for (int i = 0; i < 8; i++)
      if (srcVld[i] && mPend[i] && i != clrIdx) setv[i] = 1'b1;
    if (mState == 0)
      for (int i = 7; i >= 0; i--)
        if ((mPend[i] || srcVld[i]) && (srcMask[i] || NMI[i])) pick = i;
    mOvr = ovrClr ? setv : (mOvr | setv);
    for (int i = 0; i < 8; i++)
      if (srcVld[i]) mPend[i] = 1'b1;
      else if (i == clrIdx) mPend[i] = 1'b0;
    case (mState)
      0: if (pick >= 0) begin mSel = pick; mState = 1; end
      1: if (ack) mState = 2;
      2: if (done) mState = 0;
      default: mState = 0;
    endcase
  endfunction

  // One clock: model samples the same inputs as the DUT, outputs are read
  // 1 time unit after the edge, then single-cycle pulses are dropped.
  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    srcVld = '0; ack = 1'b0; done = 1'b0; ovrClr = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks += 4;
    if (req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", req); end
    if (excepCode !== 4'd0) begin errors++; $display("FAIL rst_code: got %0d expected 0", excepCode); end
    if (pending !== 8'h00) begin errors++; $display("FAIL rst_pend: got %h expected 00", pending); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    @(negedge clk); rst = 1'b1;
    srcMask = 8'hFF; srcVld = 8'h05; tick();
    checks += 2;
    if (req !== 1'b1) begin errors++; $display("FAIL midreq_req: got %b expected 1", req); end
    if (pending !== 8'h05) begin errors++; $display("FAIL midreq_pend: got %h expected 05", pending); end
    #1 rst = 1'b0;
    #1;
    modelReset();
    checks += 5;
    if (req !== 1'b0) begin errors++; $display("FAIL async_req: got %b expected 0", req); end
    if (excepCode !== 4'd0) begin errors++; $display("FAIL async_code: got %0d expected 0", excepCode); end
    if (pending !== 8'h00) begin errors++; $display("FAIL async_pend: got %h expected 00", pending); end
    if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", busy); end
    if (overrun !== 8'h00) begin errors++; $display("FAIL async_ovr: got %h expected 00", overrun); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single();
    srcMask = 8'hFF; srcVld = 8'h04; tick();
    checks += 3;
    if (req !== 1'b1) begin errors++; $display("FAIL single_req: got %b expected 1", req); end
    if (excepCode !== 4'd3) begin errors++; $display("FAIL single_code: got %0d expected 3", excepCode); end
    if (pending !== 8'h04) begin errors++; $display("FAIL single_pend: got %h expected 04", pending); end
    ack = 1'b1; tick();
    checks += 3;
    if (req !== 1'b0) begin errors++; $display("FAIL single_ackreq: got %b expected 0", req); end
    if (pending !== 8'h00) begin errors++; $display("FAIL single_ackpend: got %h expected 00", pending); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_svcbusy: got %b expected 1", busy); end
    done = 1'b1; tick();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_donebusy: got %b expected 0", busy); end
    if (excepCode !== 4'd0) begin errors++; $display("FAIL single_donecode: got %0d expected 0", excepCode); end
  endtask

  task automatic test_priority_mask();
    srcMask = 8'h80; srcVld = 8'h82; tick();
    checks += 2;
    if (excepCode !== 4'd8) begin errors++; $display("FAIL prio_code: got %0d expected 8", excepCode); end
    if (pending !== 8'h82) begin errors++; $display("FAIL prio_pend: got %h expected 82", pending); end
    ack = 1'b1; tick();
    done = 1'b1; tick();
    tick();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL mask_hold_busy: got %b expected 0", busy); end
    if (pending !== 8'h02) begin errors++; $display("FAIL mask_hold_pend: got %h expected 02", pending); end
    srcMask = 8'hFF; tick();
    checks += 2;
    if (req !== 1'b1) begin errors++; $display("FAIL unmask_req: got %b expected 1", req); end
    if (excepCode !== 4'd2) begin errors++; $display("FAIL unmask_code: got %0d expected 2", excepCode); end
    srcMask = 8'h00; tick();
    checks += 1;
    if (req !== 1'b1) begin errors++; $display("FAIL mask_nowithdraw: got %b expected 1", req); end
    ack = 1'b1; tick();
    done = 1'b1; tick();
  endtask

  task automatic test_nmi();
    srcMask = 8'h00; srcVld = 8'h01; tick();
    checks += 2;
    if (req !== 1'b1) begin errors++; $display("FAIL nmi_req: got %b expected 1", req); end
    if (excepCode !== 4'd1) begin errors++; $display("FAIL nmi_code: got %0d expected 1", excepCode); end
    ack = 1'b1; tick();
    done = 1'b1; tick();
  endtask

  task automatic test_overrun();
    srcMask = 8'hFF; srcVld = 8'h20; tick();
    checks += 2;
    if (excepCode !== 4'd6) begin errors++; $display("FAIL ovr_code: got %0d expected 6", excepCode); end
    if (overrun !== 8'h00) begin errors++; $display("FAIL ovr_first: got %h expected 00", overrun); end
    srcVld = 8'h20; tick();
    tick(); tick(); tick();
    checks += 1;
    if (overrun !== 8'h20) begin errors++; $display("FAIL ovr_sticky: got %h expected 20", overrun); end
    ovrClr = 1'b1; tick();
    checks += 1;
    if (overrun !== 8'h00) begin errors++; $display("FAIL ovr_clr: got %h expected 00", overrun); end
    srcVld = 8'h20; ack = 1'b1; tick();
    checks += 3;
    if (pending !== 8'h20) begin errors++; $display("FAIL setclr_pend: got %h expected 20", pending); end
    if (overrun !== 8'h00) begin errors++; $display("FAIL setclr_ovr: got %h expected 00", overrun); end
    if (req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL setclr_svc: got req=%b busy=%b expected req=0 busy=1", req, busy); end
    srcVld = 8'h20; ovrClr = 1'b1; tick();
    checks += 1;
    if (overrun !== 8'h20) begin errors++; $display("FAIL ovr_setwins: got %h expected 20", overrun); end
    done = 1'b1; tick();
    checks += 1;
    if (busy !== 1'b0) begin errors++; $display("FAIL ovr_gap: got busy=%b expected 0", busy); end
    tick();
    checks += 1;
    if (excepCode !== 4'd6 || req !== 1'b1) begin errors++; $display("FAIL ovr_rereq: got code=%0d req=%b expected 6/1", excepCode, req); end
    ack = 1'b1; tick();
    done = 1'b1; ovrClr = 1'b1; tick();
  endtask

  task automatic test_protocol();
    ack = 1'b1; tick();
    checks += 1;
    if (busy !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL ack_idle: got busy=%b req=%b expected 0/0", busy, req); end
    srcMask = 8'hFF; srcVld = 8'h08; tick();
    done = 1'b1; tick();
    checks += 1;
    if (req !== 1'b1 || excepCode !== 4'd4) begin errors++; $display("FAIL done_req: got req=%b code=%0d expected 1/4", req, excepCode); end
    done = 1'b1; ack = 1'b1; tick();
    checks += 2;
    if (req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL doneack: got req=%b busy=%b expected 0/1", req, busy); end
    if (pending !== 8'h00) begin errors++; $display("FAIL doneack_pend: got %h expected 00", pending); end
    ack = 1'b1; tick();
    checks += 1;
    if (busy !== 1'b1 || req !== 1'b0 || excepCode !== 4'd4) begin errors++; $display("FAIL ack_svc: got busy=%b req=%b code=%0d expected 1/0/4", busy, req, excepCode); end
    done = 1'b1; srcVld = 8'h02; tick();
    checks += 1;
    if (busy !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL b2b_gap: got busy=%b req=%b expected 0/0", busy, req); end
    tick();
    checks += 1;
    if (req !== 1'b1 || excepCode !== 4'd2) begin errors++; $display("FAIL b2b_next: got req=%b code=%0d expected 1/2", req, excepCode); end
    ack = 1'b1; tick();
    done = 1'b1; tick();
  endtask

  task automatic test_random();
    logic [3:0] expCode;
    for (int n = 0; n < 600; n++) begin
      srcVld = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
      if ($urandom_range(0, 15) == 0) srcMask = 8'($urandom);
      ack    = ($urandom_range(0, 1) == 1);
      done   = ($urandom_range(0, 2) == 0);
      ovrClr = ($urandom_range(0, 19) == 0);
      tick();
      expCode = (mState == 0) ? 4'd0 : 4'(mSel + 1);
      checks += 5;
      if (req !== (mState == 1)) begin errors++; $display("FAIL rnd_req @%0d: got %b expected %b", n, req, mState == 1); end
      if (busy !== (mState != 0)) begin errors++; $display("FAIL rnd_busy @%0d: got %b expected %b", n, busy, mState != 0); end
      if (excepCode !== expCode) begin errors++; $display("FAIL rnd_code @%0d: got %0d expected %0d", n, excepCode, expCode); end
      if (pending !== mPend) begin errors++; $display("FAIL rnd_pend @%0d: got %h expected %h", n, pending, mPend); end
      if (overrun !== mOvr) begin errors++; $display("FAIL rnd_ovr @%0d: got %h expected %h", n, overrun, mOvr); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority_mask();
    test_nmi();
    test_overrun();
    test_protocol();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
